line_xfer_ctrl: RTL and testbench

LINE_XFER_CTRL -- requirements
Module: line_xfer_ctrl

---
 rtl/line_xfer_pkg.sv | 21 ++
 rtl/line_xfer_tmo.sv | 30 +++
 rtl/line_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_line_xfer_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/line_xfer_pkg.sv
// Shared types and default geometry for the cache-line transfer controller.
package line_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_LOAD,
    WB_BEAT,
    FILL_BEAT,
    DONE
  } state_t;

  localparam int DEF_CASH_STR_WIDTH = 64;
  localparam int DEF_SHIFT_LEN      = 32;
  localparam int DEF_TIMEOUT        = 255;
  localparam int DEF_BEATS          = DEF_CASH_STR_WIDTH / DEF_SHIFT_LEN;

  function automatic int calc_beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

endpackage

// File: rtl/line_xfer_tmo.sv
// Per-beat ack watchdog: counts stalled cycles in a beat state, flags expiry
// on the cycle the count would reach TIMEOUT.
module line_xfer_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic not_reset,
  input  logic in_beat,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Leaving the beat states clears the count, so every beat state is entered at zero.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      cnt <= '0;
    end else if (!in_beat || ack) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = in_beat && !ack && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/line_xfer_ctrl.sv
// Sequences cache-line writeback/fill as BEATS memory beats and drives the external line shift register.
// Optional per-beat ack timeout is built only when LINE_XFER_TIMEOUT_EN is defined.
module line_xfer_ctrl
  import line_xfer_pkg::*;
#(
  parameter int CASH_STR_WIDTH = DEF_CASH_STR_WIDTH,
  parameter int SHIFT_LEN      = DEF_SHIFT_LEN,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic not_reset,
  input  logic wb_req,
  input  logic fill_req,
  output logic busy,
  output logic done,
  output logic err,
  output logic mem_rd,
  output logic mem_wr,
  input  logic mem_ack,
  output logic sr_load,
  output logic sr_mode,
  output logic sr_shift,
  output logic [$clog2(calc_beats(CASH_STR_WIDTH, SHIFT_LEN))-1:0] beat_idx
);

  localparam int BEATS = calc_beats(CASH_STR_WIDTH, SHIFT_LEN);
  localparam int IW    = $clog2(BEATS);

  state_t state;
  logic   fill_pend;
  logic   last_beat;
  logic   tmo_hit;

  assign last_beat = (beat_idx == IW'(BEATS - 1));

`ifdef LINE_XFER_TIMEOUT_EN
  logic in_beat;
  assign in_beat = (state == WB_BEAT) || (state == FILL_BEAT);

  line_xfer_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .not_reset (not_reset),
    .in_beat   (in_beat),
    .ack       (mem_ack),
    .expired   (tmo_hit)
  );

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      err <= 1'b0;
    end else if (state == IDLE && (wb_req || fill_req)) begin
      err <= 1'b0;
    end else if (tmo_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Load/shift strobes follow the ack in the same cycle the beat completes.
  assign sr_load  = (state == WB_LOAD) || (state == FILL_BEAT && mem_ack);
  assign sr_shift = (state == WB_BEAT) && mem_ack;

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state     <= IDLE;
      beat_idx  <= '0;
      fill_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      sr_mode   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          beat_idx <= '0;
          if (wb_req) begin
            state     <= WB_LOAD;
            fill_pend <= fill_req;
            busy      <= 1'b1;
            sr_mode   <= 1'b0;
          end else if (fill_req) begin
            state   <= FILL_BEAT;
            busy    <= 1'b1;
            mem_rd  <= 1'b1;
            sr_mode <= 1'b1;
          end
        end
        WB_LOAD: begin
          state    <= WB_BEAT;
          mem_wr   <= 1'b1;
          beat_idx <= '0;
        end
        WB_BEAT: begin
          if (tmo_hit) begin
            state     <= DONE;
            done      <= 1'b1;
            mem_wr    <= 1'b0;
            fill_pend <= 1'b0;
            beat_idx  <= '0;
          end else if (mem_ack) begin
            beat_idx <= last_beat ? '0 : beat_idx + IW'(1);
            if (last_beat) begin
              mem_wr <= 1'b0;
              if (fill_pend) begin
                state     <= FILL_BEAT;
                fill_pend <= 1'b0;
                mem_rd    <= 1'b1;
                sr_mode   <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        FILL_BEAT: begin
          if (tmo_hit || (mem_ack && last_beat)) begin
            state    <= DONE;
            done     <= 1'b1;
            mem_rd   <= 1'b0;
            sr_mode  <= 1'b0;
            beat_idx <= '0;
          end else if (mem_ack) begin
            beat_idx <= beat_idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Directed + randomized bench for line_xfer_ctrl; expected outputs come from a phase list per transfer.
module tb_line_xfer_ctrl;

  localparam int BEATS = 2;

  logic       clk = 1'b0;
  logic       not_reset;
  logic       wb_req, fill_req, mem_ack;
  logic       busy, done, err, mem_rd, mem_wr, sr_load, sr_mode, sr_shift;
  logic [0:0] beat_idx;

  int tests = 0;
  int fails = 0;
  logic exp_err = 1'b0;

  line_xfer_ctrl #(.CASH_STR_WIDTH(64), .SHIFT_LEN(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .not_reset (not_reset),
    .wb_req    (wb_req),
    .fill_req  (fill_req),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ack   (mem_ack),
    .sr_load   (sr_load),
    .sr_mode   (sr_mode),
    .sr_shift  (sr_shift),
    .beat_idx  (beat_idx)
  );

  always #5 clk = ~clk;

  // Field order: busy done err mem_rd mem_wr sr_load sr_mode sr_shift beat_idx
  function automatic logic [8:0] ev(input logic b, input logic d, input logic e, input logic rd,
                                    input logic wr, input logic ld, input logic md, input logic sh,
                                    input int idx);
    logic [0:0] i;
    i = idx[0:0];
    return {b, d, e, rd, wr, ld, md, sh, i};
  endfunction

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {busy, done, err, mem_rd, mem_wr, sr_load, sr_mode, sr_shift, beat_idx};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (busy,done,err,rd,wr,ld,mode,shift,idx)", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with stray acks: nothing may move.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      wb_req = 1'b0; fill_req = 1'b0; mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk); chk("idle", ev(0, 0, exp_err, 0, 0, 0, 0, 0, 0));
      step();
    end
  endtask

  // One memory beat: random stall of 0..maxd cycles then an ack; stray requests are noise.
  task automatic beat(input bit is_wr, input int b, input int maxd);
    int d;
    d = $urandom_range(0, maxd);
    for (int w = 0; w < d; w++) begin
      mem_ack = 1'b0; wb_req = 1'($urandom_range(0, 1)); fill_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk(is_wr ? "wr_wait" : "rd_wait", ev(1, 0, 0, !is_wr, is_wr, 0, !is_wr, 0, b));
      step();
    end
    mem_ack = 1'b1; wb_req = 1'b0; fill_req = 1'b0;
    @(negedge clk);
    chk(is_wr ? "wr_ack" : "rd_ack", ev(1, 0, 0, !is_wr, is_wr, !is_wr, !is_wr, is_wr, b));
    step();
  endtask

  task automatic do_xfer(input bit wb, input bit fill, input int maxd);
    wb_req = wb; fill_req = fill; mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk); chk("req_accept", ev(0, 0, exp_err, 0, 0, 0, 0, 0, 0));
    step();
    exp_err = 1'b0;
    wb_req = 1'b0; fill_req = 1'b0;
    if (wb) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk); chk("wb_load", ev(1, 0, 0, 0, 0, 1, 0, 0, 0));
      step();
      for (int b = 0; b < BEATS; b++) beat(1'b1, b, maxd);
    end
    if (fill) for (int b = 0; b < BEATS; b++) beat(1'b0, b, maxd);
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk); chk("done", ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
    step();
    idle_gap(1);
  endtask

  initial begin
    not_reset = 1'b0; wb_req = 1'b0; fill_req = 1'b0; mem_ack = 1'b0;
    #2;
    chk("reset_state", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); step();
    not_reset = 1'b1;
    idle_gap(2);

    // Fill with ack tied high: done on the third cycle after the request.
    do_xfer(1'b0, 1'b1, 0);
    // Writeback with acks three cycles late.
    wb_req = 1'b1; fill_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); chk("wb3_req", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); wb_req = 1'b0;
    @(negedge clk); chk("wb3_load", ev(1, 0, 0, 0, 0, 1, 0, 0, 0));
    step();
    for (int b = 0; b < BEATS; b++) begin
      for (int w = 0; w < 3; w++) begin
        mem_ack = 1'b0;
        @(negedge clk); chk("wb3_hold", ev(1, 0, 0, 0, 1, 0, 0, 0, b));
        step();
      end
      mem_ack = 1'b1;
      @(negedge clk); chk("wb3_shift", ev(1, 0, 0, 0, 1, 0, 0, 1, b));
      step();
    end
    mem_ack = 1'b0;
    @(negedge clk); chk("wb3_done", ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
    step();
    idle_gap(2);

    // Evict + fill in one request, then stray acks in idle.
    do_xfer(1'b1, 1'b1, 0);
    idle_gap(3);

    // Abort during the second fill beat: outputs drop immediately, no done.
    fill_req = 1'b1; mem_ack = 1'b1;
    step(); fill_req = 1'b0;
    @(negedge clk); chk("abort_beat0", ev(1, 0, 0, 1, 0, 1, 1, 0, 0));
    step();
    @(negedge clk); chk("abort_beat1", ev(1, 0, 0, 1, 0, 1, 1, 0, 1));
    #1 not_reset = 1'b0;
    #1 chk("abort_async", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    @(negedge clk); chk("abort_held", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    not_reset = 1'b1;
    step();
    idle_gap(1);
    do_xfer(1'b0, 1'b1, 2);

`ifdef LINE_XFER_TIMEOUT_EN
    // No ack ever: eight stalled cycles, then done together with err.
    fill_req = 1'b1; mem_ack = 1'b0;
    step(); fill_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); chk("tmo_wait", ev(1, 0, 0, 1, 0, 0, 1, 0, 0));
      step();
    end
    @(negedge clk); chk("tmo_done", ev(1, 1, 1, 0, 0, 0, 0, 0, 0));
    step();
    exp_err = 1'b1;
    idle_gap(2);
    do_xfer(1'b1, 1'b0, 2);
`endif

    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_xfer(kind != 1, kind != 0, 3);
      idle_gap($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
